// File: rtl/b_rx_framer_322_pkg.sv
// Shared definitions for the (3,2,2) backward-label Viterbi front end.
// Holds the FSM state encoding, the code parameters and the default pacing/FIFO sizes.
// The decoder's control unit imports the same values.
package b_rx_framer_322_pkg;

    // Convolutional code parameters: n output bits per k input bits.
    localparam int unsigned CODE_N = 3;
    localparam int unsigned CODE_K = 2;

    // Defaults shared with the decoder control unit.
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_SEQ_GAP    = 4;
    localparam int unsigned DEF_FRAME_SYMS = 16;

    // Framer FSM encoding (legacy-compatible constants).
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t StIdle    = 2'd0;
    localparam fsm_state_t StCollect = 2'd1;
    localparam fsm_state_t StFlush   = 2'd2;

    // Pointer width for a power-of-2 FIFO: index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/b_rx_framer_322_sym_fifo.sv
// b_sym_fifo: synchronous symbol FIFO with parameterised width and power-of-2 depth.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module b_sym_fifo
    import b_rx_framer_322_pkg::*;
#(
    parameter int unsigned WIDTH = CODE_N,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // The head is consumed combinationally, so its slot may be rewritten in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Pointer next-state; clear wins over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (wr_en && !clear) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/b_rx_framer_322.sv
// b_rx_framer_322: serial-to-symbol framer feeding the (3,2,2) Viterbi decoder.
// Assembles N-bit symbols MSB-first, queues them in b_sym_fifo and issues them on Rx with a
// one-cycle seq_ready strobe, at least SEQ_GAP cycles apart.
// Optional feature macro: RX_RESYNC_EN (rising sync_error aborts the current frame).
module b_rx_framer_322
    import b_rx_framer_322_pkg::*;
#(
    parameter int unsigned N          = CODE_N,
    parameter int unsigned FRAME_SYMS = DEF_FRAME_SYMS,
    parameter int unsigned SEQ_GAP    = DEF_SEQ_GAP,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic         frame_start,
    input  logic         sync_error,
    output logic [N-1:0] Rx,
    output logic         seq_ready,
    output logic         frame_done,
    output logic         overflow,
    output logic         busy
);

    localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SYM_W = $clog2(FRAME_SYMS + 1);
    localparam int unsigned GAP_W = 4;

    fsm_state_t       state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N-1:0]     rx_q, rx_d;
    logic             seq_ready_q;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic             start_ok;
    logic             take_bit;
    logic [BIT_W-1:0] bit_base;
    logic [SYM_W-1:0] sym_base;
    logic [SYM_W-1:0] sym_next;
    logic [N-1:0]     new_sym;
    logic             sym_done;
    logic             resync;
    logic             can_issue;
    logic             issue_head;
    logic             bypass;
    logic             issue;
    logic             fifo_push;
    logic             fifo_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [N-1:0]     fifo_head;

`ifdef RX_RESYNC_EN
    logic sync_q;

    // Previous sync_error level for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 1'b0;
        else        sync_q <= sync_error;
    end

    assign resync = sync_error && !sync_q && (state_q != StIdle);
`else
    logic unused_sync_error;
    assign unused_sync_error = sync_error;
    assign resync            = 1'b0;
`endif

    // A frame_start is honoured only from IDLE; its same-cycle bit is bit 0 of the frame.
    assign start_ok = (state_q == StIdle) && frame_start;
    assign take_bit = ser_valid && (start_ok || (state_q == StCollect));
    assign bit_base = start_ok ? '0 : bit_cnt_q;
    assign sym_base = start_ok ? '0 : sym_cnt_q;
    assign sym_next = sym_base + SYM_W'(1);
    assign new_sym  = N'({shift_q, ser_in});
    assign sym_done = take_bit && (bit_base == BIT_W'(N - 1));

    // A symbol completing into an empty FIFO bypasses it so the strobe follows one cycle later.
    assign can_issue  = (gap_q == '0) && !resync;
    assign issue_head = can_issue && !fifo_empty;
    assign bypass     = can_issue && fifo_empty && sym_done;
    assign issue      = issue_head || bypass;
    assign fifo_push  = sym_done && !bypass;
    assign fifo_clear = start_ok || resync;

    b_sym_fifo #(
        .WIDTH (N),
        .DEPTH (FIFO_DEPTH)
    ) u_sym_fifo (
        .clock (clock),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (issue_head),
        .wdata (new_sym),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame FSM, bit/symbol counters and shift register.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;

        if (start_ok) begin
            state_d   = StCollect;
            bit_cnt_d = '0;
            sym_cnt_d = '0;
        end

        if (take_bit) begin
            shift_d = new_sym;
            if (sym_done) begin
                bit_cnt_d = '0;
                sym_cnt_d = sym_next;
                // Dropped symbols still count, so the frame always terminates.
                if (sym_next == SYM_W'(FRAME_SYMS)) state_d = StFlush;
            end else begin
                bit_cnt_d = bit_base + BIT_W'(1);
            end
        end

        // Empty FIFO in FLUSH means the last strobe is already on the outputs.
        if ((state_q == StFlush) && fifo_empty) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
        end

        if (resync) begin
            state_d      = StIdle;
            bit_cnt_d    = '0;
            frame_done_d = 1'b0;
        end
    end

    // Issue path: output symbol, pacing counter and sticky overflow.
    always_comb begin
        rx_d       = rx_q;
        gap_d      = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
        overflow_d = overflow_q;

        if (issue) begin
            rx_d  = issue_head ? fifo_head : new_sym;
            gap_d = GAP_W'(SEQ_GAP - 1);
        end

        if (start_ok) begin
            overflow_d = 1'b0;
        end else if (sym_done && fifo_full && !issue_head) begin
            overflow_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            shift_q      <= '0;
            gap_q        <= '0;
            rx_q         <= '0;
            seq_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            shift_q      <= shift_d;
            gap_q        <= gap_d;
            rx_q         <= rx_d;
            seq_ready_q  <= issue;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign Rx         = rx_q;
    assign seq_ready  = seq_ready_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/b_rx_framer_322.md
# b_rx_framer_322

Input symbol framer for the (3,2,2) backward-label Viterbi decoder. It collects a serial channel bit stream into 3-bit received symbols and buffers them in a small FIFO. It presents one symbol at a time on `Rx` with a one-cycle `seq_ready` strobe, paced so the decoder's control unit has time to finish each trellis step. It sits directly upstream of the decoder top level and drives its `Rx` and `seq_ready` inputs.

## Interface
- `N`, 3: symbol width; equals the code's `n`.
- `FRAME_SYMS`, 16: number of symbols per frame, range 1..1023.
- `SEQ_GAP`, 4: minimum number of cycles between `seq_ready` pulses, range 1..15.
- `FIFO_DEPTH`, 4: symbol FIFO depth; must be a power of 2, at least 2.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ser_in`  in  1  serial channel bit.
- `ser_valid`  in  1  `ser_in` is valid this cycle.
- `frame_start`  in  1  single-cycle pulse that opens a frame.
- `sync_error`  in  1  decoder sync-error flag; used only when `RX_RESYNC_EN` is defined.
- `Rx`  out  N  current symbol to the decoder.
- `seq_ready`  out  1  one-cycle strobe; `Rx` is valid in the same cycle.
- `frame_done`  out  1  one-cycle pulse issued after the frame's last symbol.
- `overflow`  out  1  sticky symbol-drop flag.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, COLLECT, FLUSH.
- **IDLE:**
  - `ser_valid` is ignored.
  - `frame_start` moves the FSM to COLLECT, clears the bit counter, symbol counter and `overflow`, and empties the FIFO.
  - If `ser_valid` is high in the same cycle as `frame_start`, that bit is accepted as bit 0 of the frame.
- **COLLECT:**
  - Each valid bit shifts in MSB-first: the first bit of a symbol lands in `Rx[N-1]`.
  - A bit counter runs 0..N-1. On the N-th bit the completed symbol is pushed to the FIFO and the symbol counter increments.
  - When the symbol counter reaches `FRAME_SYMS`, the FSM moves to FLUSH. Any further `ser_valid` bits are ignored.
- **FIFO full:** if a symbol completes while the FIFO is full, that symbol is dropped and `overflow` is set. The symbol still counts toward `FRAME_SYMS`.
- **FLUSH:**
  - When the FIFO is empty and the final `seq_ready` has been issued, `frame_done` pulses for one cycle and the FSM returns to IDLE.
  - `frame_done` is therefore the cycle after the last strobe at the earliest.
- **Issue rule:**
  - A symbol is issued when the FIFO is non-empty and the pacing counter equals 0.
  - On issue, the FIFO head is registered onto `Rx`, `seq_ready` is asserted, and the pacing counter is loaded with `SEQ_GAP-1`.
  - The pacing counter decrements each cycle and saturates at 0.
- **`Rx` holding:** `Rx` keeps the last issued symbol between strobes.
- **Late `frame_start`:** a `frame_start` in COLLECT or FLUSH is ignored.
- **Simultaneous push and pop on a full FIFO:** allowed, with no overflow.
- **Counters and pointers:** all counters are unsigned. FIFO pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally.

## Timing
- **Reset values:** `Rx`=0, `seq_ready`=0, `frame_done`=0, `overflow`=0, `busy`=0, FSM=IDLE, FIFO empty, pacing counter=0.
- **Reset during a frame:** all state is discarded immediately (asynchronous).
- **Latency:** if the bit that completes a symbol arrives in cycle t into an empty FIFO with the pacing counter at 0, `seq_ready` is asserted in cycle t+1.
- **Pacing:** the spacing between consecutive strobes is at least `SEQ_GAP` cycles. With `SEQ_GAP`=1, strobes can occur back-to-back.
- **`busy`:** rises the cycle after `frame_start` is accepted and falls in the same cycle as the `frame_done` pulse.

## Configuration
- **`RX_RESYNC_EN` defined:**
  - A rising edge on `sync_error` in COLLECT or FLUSH empties the FIFO, clears the bit counter and returns the FSM to IDLE.
  - No `frame_done` is issued.
  - `overflow` is held.
- **`RX_RESYNC_EN` undefined:** `sync_error` is unused and the edge-detect register is not built.

## Structure
- **Shared package:** the FSM state encoding, the `n` and `k` values, and the default `FIFO_DEPTH` and `SEQ_GAP`. These are shared with the decoder's control unit.
- **Sub-module `b_sym_fifo`:** a synchronous FIFO with parameterised width and depth, push/pop inputs, and full/empty outputs. Its occupancy logic is verified standalone.

## Test plan
- **Basic frame:** `FRAME_SYMS`=2, `SEQ_GAP`=1, bits 1,0,1,1,1,0 on consecutive cycles → `Rx`=3'b101 then 3'b110, two `seq_ready` pulses, then `frame_done` in the following cycle.
- **Pacing:** `SEQ_GAP`=4, 4 symbols arrive in a burst → strobes exactly 4 cycles apart, `overflow`=0.
- **Overflow:** `FIFO_DEPTH`=2, `SEQ_GAP`=15, 4 symbols in 12 cycles → `overflow`=1, only the first 3 symbols issued, `frame_done` still pulses, `overflow` cleared by the next `frame_start`.
- **Start edge cases:** `frame_start` with `ser_valid`=1, `ser_in`=1 → the first symbol's MSB is 1. A second `frame_start` during COLLECT → no effect.
- **Async reset mid-frame:** `reset` low for 1 cycle after 2 bits → all outputs 0, and the next frame assembles from bit 0.
- **Resync (`RX_RESYNC_EN` defined):** `sync_error` rises during COLLECT with 2 symbols queued → no further `seq_ready`, `busy`=0 next cycle, no `frame_done`.
